// File: rtl/alarm_bank_ctrl.sv
// Multi-entry BCD alarm bank with ring / snooze / timeout sequencing.
// Entries are compared against the current time on each minute tick; the lowest matching index wins.
module alarm_bank_ctrl #(
  parameter int NUM_ALARMS  = 4,
  parameter int IDX_W       = 2,
  parameter int SNOOZE_MIN  = 5,
  parameter int MAX_SNOOZE  = 3,
  parameter int TIMEOUT_SEC = 60
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             one_sec,
  input  logic             min_tick,
  input  logic [15:0]      cur_time,
  input  logic             alarm_load,
  input  logic [IDX_W-1:0] alarm_idx,
  input  logic [15:0]      alarm_time,
  input  logic             alarm_en_wr,
  input  logic             snooze,
  input  logic             stop,
  output logic             alarm_sound,
  output logic [IDX_W-1:0] active_idx,
  output logic             snoozing,
  output logic             missed,
  output logic             load_err
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_SEC - 1);
  localparam logic [7:0] MAX_SNZ      = 8'(MAX_SNOOZE);
  localparam logic [3:0] SNZ_INIT     = 4'(SNOOZE_MIN);

  function automatic logic bcd_ok(input logic [15:0] t);
    logic [3:0] h1, h0, m1, m0;
    h1 = t[15:12];
    h0 = t[11:8];
    m1 = t[7:4];
    m0 = t[3:0];
    return (h1 <= 4'd2) && (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
           !((h1 == 4'd2) && (h0 > 4'd3));
  endfunction

  logic [15:0]           alarm_mem [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_mem;

  state_t           state_q, state_d;
  logic [7:0]       sec_cnt_q, sec_cnt_d;
  logic [3:0]       snz_cnt_q, snz_cnt_d;
  logic [7:0]       snz_used_q, snz_used_d;
  logic [IDX_W-1:0] active_q, active_d;
  logic             missed_q, load_err_q;

  logic             load_ok, cancel, hit;
  logic [IDX_W-1:0] win;

  assign load_ok = alarm_load && bcd_ok(alarm_time) && (32'(alarm_idx) < NUM_ALARMS);
  assign cancel  = load_ok && (alarm_idx == active_q) && (state_q != IDLE);

  // Entry storage: a same-cycle tick still compares against the old contents
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) alarm_mem[i] <= 16'h0000;
      en_mem <= '0;
    end else if (load_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (32'(alarm_idx) == i) begin
          alarm_mem[i] <= alarm_time;
          en_mem[i]    <= alarm_en_wr;
        end
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (en_mem[i] && (alarm_mem[i] == cur_time)) begin
        hit = 1'b1;
        win = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sec_cnt_d  = sec_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    snz_used_d = snz_used_q;
    active_d   = active_q;
    case (state_q)
      IDLE: begin
        if (min_tick && hit) begin
          state_d    = RING;
          active_d   = win;
          sec_cnt_d  = 8'd0;
          snz_used_d = 8'd0;
        end
      end
      RING: begin
        if (cancel || stop) begin
          state_d = IDLE;
        end else if (snooze) begin
          if (snz_used_q < MAX_SNZ) begin
            state_d    = SNOOZE;
            snz_cnt_d  = SNZ_INIT;
            snz_used_d = snz_used_q + 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else if (one_sec) begin
          if (sec_cnt_q == TIMEOUT_LAST) state_d = IDLE;
          else sec_cnt_d = sec_cnt_q + 8'd1;
        end
      end
      SNOOZE: begin
        if (cancel || stop) begin
          state_d = IDLE;
        end else if (min_tick) begin
          if (snz_cnt_q == 4'd1) begin
            state_d   = RING;
            sec_cnt_d = 8'd0;
          end
          snz_cnt_d = snz_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sec_cnt_q  <= 8'd0;
      snz_cnt_q  <= 4'd0;
      snz_used_q <= 8'd0;
      active_q   <= '0;
      missed_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      snz_used_q <= snz_used_d;
      active_q   <= active_d;
      missed_q   <= min_tick && hit && (state_q != IDLE);
      load_err_q <= alarm_load && !load_ok;
    end
  end

  assign alarm_sound = (state_q == RING);
  assign snoozing    = (state_q == SNOOZE);
  assign active_idx  = active_q;
  assign missed      = missed_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_alarm_bank_ctrl.sv
// Directed bench for alarm_bank_ctrl: load, priority, snooze, timeout, errors, reset.
module tb_alarm_bank_ctrl;

  logic        clock = 1'b0;
  logic        reset, one_sec, min_tick, alarm_load, alarm_en_wr, snooze, stop;
  logic [15:0] cur_time, alarm_time;
  logic [1:0]  alarm_idx;
  logic        alarm_sound, snoozing, missed, load_err;
  logic [1:0]  active_idx;

  int checks = 0;
  int fails  = 0;

  alarm_bank_ctrl dut (
    .clock(clock), .reset(reset), .one_sec(one_sec), .min_tick(min_tick),
    .cur_time(cur_time), .alarm_load(alarm_load), .alarm_idx(alarm_idx),
    .alarm_time(alarm_time), .alarm_en_wr(alarm_en_wr), .snooze(snooze),
    .stop(stop), .alarm_sound(alarm_sound), .active_idx(active_idx),
    .snoozing(snoozing), .missed(missed), .load_err(load_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [15:0] t, input logic en);
    alarm_load = 1'b1; alarm_idx = idx; alarm_time = t; alarm_en_wr = en;
    tick();
    alarm_load = 1'b0;
  endtask

  task automatic mtick(input logic [15:0] t);
    cur_time = t; min_tick = 1'b1;
    tick();
    min_tick = 1'b0;
  endtask

  task automatic sec_pulse();
    one_sec = 1'b1; tick(); one_sec = 1'b0;
  endtask

  task automatic press_snooze();
    snooze = 1'b1; tick(); snooze = 1'b0;
  endtask

  task automatic press_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; one_sec = 0; min_tick = 0; cur_time = 16'h0000; alarm_load = 0;
    alarm_idx = 0; alarm_time = 16'h0000; alarm_en_wr = 0; snooze = 0; stop = 0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (alarm_sound !== 1'b0) begin fails++; $display("FAIL reset_sound: got %b want 0", alarm_sound); end
    checks++; if (active_idx !== 2'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", active_idx); end
    checks++; if ({snoozing, missed, load_err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {snoozing, missed, load_err}); end
    mtick(16'h0000);
    checks++; if (alarm_sound !== 1'b0) begin fails++; $display("FAIL reset_disabled_entry: got %b want 0", alarm_sound); end
  endtask

  task automatic test_single();
    load(2'd1, 16'h0730, 1'b1);
    mtick(16'h0730);
    checks++; if (alarm_sound !== 1'b1) begin fails++; $display("FAIL single_sound: got %b want 1", alarm_sound); end
    checks++; if (active_idx !== 2'd1) begin fails++; $display("FAIL single_idx: got %0d want 1", active_idx); end
    press_stop();
    checks++; if (alarm_sound !== 1'b0) begin fails++; $display("FAIL single_stop: got %b want 0", alarm_sound); end
    // load and tick in the same cycle: compare sees the old (disabled) entry
    alarm_load = 1'b1; alarm_idx = 2'd3; alarm_time = 16'h0900; alarm_en_wr = 1'b1;
    cur_time = 16'h0900; min_tick = 1'b1;
    tick();
    alarm_load = 1'b0; min_tick = 1'b0;
    checks++; if (alarm_sound !== 1'b0) begin fails++; $display("FAIL same_cycle_load: got %b want 0", alarm_sound); end
    mtick(16'h0900);
    checks++; if ({alarm_sound, active_idx} !== 3'b111) begin fails++; $display("FAIL later_tick: got %b want 111", {alarm_sound, active_idx}); end
    press_stop();
  endtask

  task automatic test_priority();
    load(2'd0, 16'h0600, 1'b1);
    load(2'd2, 16'h0600, 1'b1);
    mtick(16'h0600);
    checks++; if ({alarm_sound, active_idx} !== 3'b100) begin fails++; $display("FAIL prio_low: got %b want 100", {alarm_sound, active_idx}); end
    press_stop();
    load(2'd0, 16'h0600, 1'b0);
    mtick(16'h0600);
    checks++; if ({alarm_sound, active_idx} !== 3'b110) begin fails++; $display("FAIL prio_disabled: got %b want 110", {alarm_sound, active_idx}); end
    press_stop();
  endtask

  task automatic test_snooze();
    mtick(16'h0730);
    press_snooze();
    checks++; if ({alarm_sound, snoozing} !== 2'b01) begin fails++; $display("FAIL snooze_enter: got %b want 01", {alarm_sound, snoozing}); end
    for (int k = 0; k < 4; k++) mtick(16'h1200);
    checks++; if ({alarm_sound, snoozing} !== 2'b01) begin fails++; $display("FAIL snooze_4ticks: got %b want 01", {alarm_sound, snoozing}); end
    mtick(16'h1200);
    checks++; if ({alarm_sound, snoozing} !== 2'b10) begin fails++; $display("FAIL snooze_rering: got %b want 10", {alarm_sound, snoozing}); end
    for (int s = 0; s < 2; s++) begin
      press_snooze();
      for (int k = 0; k < 5; k++) mtick(16'h1200);
    end
    checks++; if (alarm_sound !== 1'b1) begin fails++; $display("FAIL snooze_third_rering: got %b want 1", alarm_sound); end
    press_snooze();
    checks++; if ({alarm_sound, snoozing} !== 2'b00) begin fails++; $display("FAIL snooze_limit: got %b want 00", {alarm_sound, snoozing}); end
  endtask

  task automatic test_timeout();
    logic held;
    held = 1'b1;
    mtick(16'h0730);
    for (int k = 0; k < 59; k++) begin
      sec_pulse();
      if (alarm_sound !== 1'b1) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin fails++; $display("FAIL timeout_hold: got %b want 1", held); end
    sec_pulse();
    checks++; if (alarm_sound !== 1'b0) begin fails++; $display("FAIL timeout_60: got %b want 0", alarm_sound); end
    mtick(16'h0730);
    stop = 1'b1; snooze = 1'b1;
    tick();
    stop = 1'b0; snooze = 1'b0;
    checks++; if ({alarm_sound, snoozing} !== 2'b00) begin fails++; $display("FAIL stop_and_snooze: got %b want 00", {alarm_sound, snoozing}); end
  endtask

  task automatic test_errors();
    load(2'd1, 16'h2400, 1'b1);
    checks++; if (load_err !== 1'b1) begin fails++; $display("FAIL err_2400: got %b want 1", load_err); end
    tick();
    checks++; if (load_err !== 1'b0) begin fails++; $display("FAIL err_pulse_end: got %b want 0", load_err); end
    load(2'd1, 16'h1260, 1'b1);
    checks++; if (load_err !== 1'b1) begin fails++; $display("FAIL err_1260: got %b want 1", load_err); end
    mtick(16'h0730);
    checks++; if ({alarm_sound, active_idx} !== 3'b101) begin fails++; $display("FAIL err_entry_kept: got %b want 101", {alarm_sound, active_idx}); end
    mtick(16'h0900);
    checks++; if ({missed, alarm_sound, active_idx} !== 4'b1101) begin fails++; $display("FAIL missed_pulse: got %b want 1101", {missed, alarm_sound, active_idx}); end
    tick();
    checks++; if (missed !== 1'b0) begin fails++; $display("FAIL missed_end: got %b want 0", missed); end
    load(2'd1, 16'h0730, 1'b1);
    checks++; if (alarm_sound !== 1'b0) begin fails++; $display("FAIL load_cancel: got %b want 0", alarm_sound); end
  endtask

  task automatic test_reset_mid();
    mtick(16'h0730);
    press_snooze();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if ({alarm_sound, snoozing, missed, load_err, active_idx} !== 6'b0) begin fails++; $display("FAIL reset_snooze: got %b want 000000", {alarm_sound, snoozing, missed, load_err, active_idx}); end
    load(2'd1, 16'h0730, 1'b1);
    mtick(16'h0730);
    checks++; if (alarm_sound !== 1'b1) begin fails++; $display("FAIL reload_ring: got %b want 1", alarm_sound); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if ({alarm_sound, snoozing, active_idx} !== 4'b0) begin fails++; $display("FAIL reset_ring: got %b want 0000", {alarm_sound, snoozing, active_idx}); end
    mtick(16'h0730);
    checks++; if (alarm_sound !== 1'b0) begin fails++; $display("FAIL reset_cleared: got %b want 0", alarm_sound); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_snooze();
    test_timeout();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
